// File: rtl/result_exception_stage_pkg.sv
// Shared FPU result-select encodings, rounding modes and the stage payload type.
// RESULT encodes as zero in every select so a cleared register reads as "pass the computed value".
package sign;
  typedef enum logic [1:0] {RESULT = 2'd0, ZERO = 2'd1, ONE = 2'd2} select_t;
endpackage

package exponent;
  typedef enum logic [1:0] {RESULT = 2'd0, ZEROS = 2'd1, ONES = 2'd2, MAX_FINITE = 2'd3} select_t;
endpackage

package fraction_msb;
  typedef enum logic [1:0] {RESULT = 2'd0, ZERO = 2'd1, ONE = 2'd2} select_t;
endpackage

package fraction_lsbs;
  typedef enum logic [1:0] {RESULT = 2'd0, ZEROS = 2'd1, ONES = 2'd2} select_t;
endpackage

package fpu_round;
  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3} round_mode_t;
endpackage

package result_exception_stage_pkg;
  typedef struct packed {
    sign::select_t          sign_sel;
    exponent::select_t      exp_sel;
    fraction_msb::select_t  msb_sel;
    fraction_lsbs::select_t lsbs_sel;
    logic                   ovf;
    logic                   unf;
  } result_t;

  localparam int RESULT_W = $bits(result_t);
endpackage

// File: rtl/result_exception_stage_if.sv
// Upstream/downstream bundle of the exception stage; slave is the stage's view, master the environment's.
interface result_exception_stage_if #(
  parameter int XEXP_WIDTH = 10,
  parameter int FRAC_WIDTH = 32
);
  logic                   valid_in;
  logic                   ready_in;
  sign::select_t          sign_select_in;
  exponent::select_t      exponent_select_in;
  fraction_msb::select_t  fraction_msb_select_in;
  fraction_lsbs::select_t fraction_lsbs_select_in;
  fpu_round::round_mode_t round_mode_in;
  logic                   result_sign;
  logic [XEXP_WIDTH-1:0]  result_exponent;
  logic [FRAC_WIDTH-1:0]  result_fraction;
  logic                   valid_out;
  logic                   ready_out;
  sign::select_t          sign_select_out;
  exponent::select_t      exponent_select_out;
  fraction_msb::select_t  fraction_msb_select_out;
  fraction_lsbs::select_t fraction_lsbs_select_out;
  logic                   overflow_out;
  logic                   underflow_out;
  logic                   flags_clear;
  logic                   sticky_overflow;
  logic                   sticky_underflow;

  modport slave (
    input  valid_in, sign_select_in, exponent_select_in, fraction_msb_select_in,
           fraction_lsbs_select_in, round_mode_in, result_sign, result_exponent,
           result_fraction, ready_out, flags_clear,
    output ready_in, valid_out, sign_select_out, exponent_select_out,
           fraction_msb_select_out, fraction_lsbs_select_out, overflow_out,
           underflow_out, sticky_overflow, sticky_underflow
  );

  modport master (
    output valid_in, sign_select_in, exponent_select_in, fraction_msb_select_in,
           fraction_lsbs_select_in, round_mode_in, result_sign, result_exponent,
           result_fraction, ready_out, flags_clear,
    input  ready_in, valid_out, sign_select_out, exponent_select_out,
           fraction_msb_select_out, fraction_lsbs_select_out, overflow_out,
           underflow_out, sticky_overflow, sticky_underflow
  );
endinterface

// File: rtl/result_exception_stage_decode.sv
// Combinational zero/overflow/underflow rewrite of the result selects.
// Zero latency, no state; special-case selects pass through untouched.
module result_exception_decode
  import result_exception_stage_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 32,
  parameter int XEXP_WIDTH = EXP_WIDTH + 2
) (
  input  sign::select_t          i_sign_sel,
  input  exponent::select_t      i_exp_sel,
  input  fraction_msb::select_t  i_msb_sel,
  input  fraction_lsbs::select_t i_lsbs_sel,
  input  fpu_round::round_mode_t i_round_mode,
  input  logic                   i_sign,
  input  logic [XEXP_WIDTH-1:0]  i_exponent,
  input  logic [FRAC_WIDTH-1:0]  i_fraction,
  output result_t                o_res
);
  localparam logic signed [XEXP_WIDTH-1:0] EXP_MAX  = XEXP_WIDTH'((1 << EXP_WIDTH) - 1);
  localparam logic signed [XEXP_WIDTH-1:0] EXP_ZERO = '0;

  logic w_all_result, w_zero, w_ovf, w_unf, w_to_inf;

  assign w_all_result = (i_sign_sel == sign::RESULT) && (i_exp_sel == exponent::RESULT) &&
                        (i_msb_sel == fraction_msb::RESULT) && (i_lsbs_sel == fraction_lsbs::RESULT);
  assign w_zero   = ~|i_fraction;
  assign w_ovf    = $signed(i_exponent) >= EXP_MAX;
  assign w_unf    = $signed(i_exponent) <= EXP_ZERO;
  // Overflow rounds to infinity only when the rounding direction points away from zero.
  assign w_to_inf = (i_round_mode == fpu_round::RNE) ||
                    (i_round_mode == fpu_round::RUP && !i_sign) ||
                    (i_round_mode == fpu_round::RDN && i_sign);

  always_comb begin
    o_res = '{i_sign_sel, i_exp_sel, i_msb_sel, i_lsbs_sel, 1'b0, 1'b0};
    if (w_all_result) begin
      if (w_zero) begin
        o_res = '{sign::ZERO, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b0, 1'b0};
      end else if (w_ovf) begin
        if (w_to_inf)
          o_res = '{sign::RESULT, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b1, 1'b0};
        else
          o_res = '{sign::RESULT, exponent::MAX_FINITE, fraction_msb::ONE, fraction_lsbs::ONES, 1'b1, 1'b0};
      end else if (w_unf) begin
        o_res = '{sign::RESULT, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b0, 1'b1};
      end
    end
  end
endmodule

// File: rtl/result_exception_stage_skid.sv
// Two-entry skid buffer, main register drives the output; latency 1.
// o_rdy is registered (low only when skid is occupied); payload holds while stalled.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_dat
);
  logic [WIDTH-1:0] r_main, r_skid;
  logic             r_main_vld, r_skid_vld, r_rdy;
  logic             w_accept, w_hs, w_load_main;

  assign w_accept    = i_vld & r_rdy;
  assign w_hs        = r_main_vld & i_rdy;
  assign w_load_main = w_hs | ~r_main_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_rdy      <= 1'b1;
    end else if (w_load_main) begin
      // r_rdy is low whenever skid holds data, so no new input competes with the refill.
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
        r_rdy      <= 1'b1;
      end else begin
        r_main_vld <= w_accept;
        if (w_accept) r_main <= i_dat;
      end
    end else if (w_accept) begin
      r_skid     <= i_dat;
      r_skid_vld <= 1'b1;
      r_rdy      <= 1'b0;
    end
  end

  assign o_rdy = r_rdy;
  assign o_vld = r_main_vld;
  assign o_dat = r_main;
endmodule

// File: rtl/result_exception_stage.sv
// FPU exception/result-select stage with sticky IEEE overflow/underflow flags.
// Latency 1, full throughput; skid buffer absorbs one result when downstream stalls.
module result_exception_stage
  import result_exception_stage_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 32,
  parameter int XEXP_WIDTH = EXP_WIDTH + 2
) (
  input logic                     clk,
  input logic                     reset_n,
  result_exception_stage_if.slave bus
);
  result_t w_dec, w_out;
  logic    w_hs;
  logic    r_sticky_ovf, r_sticky_unf;

  result_exception_decode #(
    .EXP_WIDTH (EXP_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .XEXP_WIDTH(XEXP_WIDTH)
  ) u_decode (
    .i_sign_sel  (bus.sign_select_in),
    .i_exp_sel   (bus.exponent_select_in),
    .i_msb_sel   (bus.fraction_msb_select_in),
    .i_lsbs_sel  (bus.fraction_lsbs_select_in),
    .i_round_mode(bus.round_mode_in),
    .i_sign      (bus.result_sign),
    .i_exponent  (bus.result_exponent),
    .i_fraction  (bus.result_fraction),
    .o_res       (w_dec)
  );

  skid_buffer #(.WIDTH(RESULT_W)) u_skid (
    .clk  (clk),
    .rst_n(reset_n),
    .i_vld(bus.valid_in),
    .o_rdy(bus.ready_in),
    .i_dat(w_dec),
    .o_vld(bus.valid_out),
    .i_rdy(bus.ready_out),
    .o_dat(w_out)
  );

  assign w_hs = bus.valid_out & bus.ready_out;

  // Clear takes effect before the handshaking result's bits are merged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky_ovf <= 1'b0;
      r_sticky_unf <= 1'b0;
    end else begin
      r_sticky_ovf <= (r_sticky_ovf & ~bus.flags_clear) | (w_hs & w_out.ovf);
      r_sticky_unf <= (r_sticky_unf & ~bus.flags_clear) | (w_hs & w_out.unf);
    end
  end

  assign bus.sign_select_out          = w_out.sign_sel;
  assign bus.exponent_select_out      = w_out.exp_sel;
  assign bus.fraction_msb_select_out  = w_out.msb_sel;
  assign bus.fraction_lsbs_select_out = w_out.lsbs_sel;
  assign bus.overflow_out             = w_out.ovf;
  assign bus.underflow_out            = w_out.unf;
  assign bus.sticky_overflow          = r_sticky_ovf;
  assign bus.sticky_underflow         = r_sticky_unf;
endmodule

// File: tb/tb_result_exception_stage.sv
// Directed bench for result_exception_stage: decode vector table, sticky-flag and stall/reset sequences.
module tb_result_exception_stage;
  import result_exception_stage_pkg::*;

  typedef enum int {C_INF, C_MAX, C_UNF, C_ZERO, C_NORM, C_PASS} cat_t;

  typedef struct {
    sign::select_t          s;
    exponent::select_t      e;
    fraction_msb::select_t  m;
    fraction_lsbs::select_t l;
    fpu_round::round_mode_t rm;
    logic                   sg;
    logic [9:0]             ex;
    logic [31:0]            fr;
    cat_t                   cat;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  vec_t tbl [18];

  always #5 clk = ~clk;

  result_exception_stage_if #(.XEXP_WIDTH(10), .FRAC_WIDTH(32)) bus ();

  result_exception_stage #(
    .EXP_WIDTH (8),
    .FRAC_WIDTH(32),
    .XEXP_WIDTH(10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic vec_t nv(fpu_round::round_mode_t rm, logic sg, logic [9:0] ex,
                              logic [31:0] fr, cat_t c);
    vec_t v;
    v = '{sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT,
          rm, sg, ex, fr, c};
    return v;
  endfunction

  function automatic vec_t pv(sign::select_t s, exponent::select_t e, fraction_msb::select_t m,
                              fraction_lsbs::select_t l, fpu_round::round_mode_t rm, logic sg,
                              logic [9:0] ex, logic [31:0] fr);
    vec_t v;
    v = '{s, e, m, l, rm, sg, ex, fr, C_PASS};
    return v;
  endfunction

  function automatic result_t expect_of(vec_t v);
    result_t r;
    case (v.cat)
      C_INF:  r = '{sign::RESULT, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b1, 1'b0};
      C_MAX:  r = '{sign::RESULT, exponent::MAX_FINITE, fraction_msb::ONE, fraction_lsbs::ONES, 1'b1, 1'b0};
      C_UNF:  r = '{sign::RESULT, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b0, 1'b1};
      C_ZERO: r = '{sign::ZERO, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS, 1'b0, 1'b0};
      C_PASS: r = '{v.s, v.e, v.m, v.l, 1'b0, 1'b0};
      default: r = '{sign::RESULT, exponent::RESULT, fraction_msb::RESULT, fraction_lsbs::RESULT, 1'b0, 1'b0};
    endcase
    return r;
  endfunction

  function automatic result_t got();
    result_t r;
    r = '{bus.sign_select_out, bus.exponent_select_out, bus.fraction_msb_select_out,
          bus.fraction_lsbs_select_out, bus.overflow_out, bus.underflow_out};
    return r;
  endfunction

  function automatic logic [31:0] r2l(result_t r);
    logic [31:0] t;
    t = '0;
    t[RESULT_W-1:0] = r;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.valid_in                = 1'b1;
    bus.sign_select_in          = v.s;
    bus.exponent_select_in      = v.e;
    bus.fraction_msb_select_in  = v.m;
    bus.fraction_lsbs_select_in = v.l;
    bus.round_mode_in           = v.rm;
    bus.result_sign             = v.sg;
    bus.result_exponent         = v.ex;
    bus.result_fraction         = v.fr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s_ovf, s_unf;
    result_t q[$];
    result_t e;
    int cnt, sent, recvd;
    logic acc, hs;

    tbl[0]  = nv(fpu_round::RNE, 1'b0, 10'd255, 32'h8000_0000, C_INF);
    tbl[1]  = nv(fpu_round::RTZ, 1'b1, 10'd300, 32'h0000_0001, C_MAX);
    tbl[2]  = nv(fpu_round::RNE, 1'b0, 10'h3FD, 32'h0000_0100, C_UNF);
    tbl[3]  = nv(fpu_round::RNE, 1'b0, 10'd0,   32'h0000_0000, C_ZERO);
    tbl[4]  = pv(sign::RESULT, exponent::ONES, fraction_msb::ONE, fraction_lsbs::ZEROS,
                 fpu_round::RNE, 1'b0, 10'd400, 32'h4000_0000);
    tbl[5]  = nv(fpu_round::RNE, 1'b0, 10'd127, 32'h0000_0123, C_NORM);
    tbl[6]  = pv(sign::ONE, exponent::ZEROS, fraction_msb::ZERO, fraction_lsbs::ZEROS,
                 fpu_round::RNE, 1'b1, 10'd300, 32'h0000_0001);
    tbl[7]  = pv(sign::RESULT, exponent::ONES, fraction_msb::ZERO, fraction_lsbs::ZEROS,
                 fpu_round::RUP, 1'b0, 10'h3F0, 32'h0000_0001);
    tbl[8]  = nv(fpu_round::RDN, 1'b1, 10'd300, 32'h0000_0001, C_INF);
    tbl[9]  = nv(fpu_round::RDN, 1'b0, 10'd300, 32'h0000_0001, C_MAX);
    tbl[10] = nv(fpu_round::RUP, 1'b0, 10'd255, 32'h0000_0001, C_INF);
    tbl[11] = nv(fpu_round::RUP, 1'b1, 10'd255, 32'h0000_0001, C_MAX);
    tbl[12] = nv(fpu_round::RNE, 1'b0, 10'd254, 32'h0000_0001, C_NORM);
    tbl[13] = nv(fpu_round::RTZ, 1'b0, 10'd1,   32'h0000_0001, C_NORM);
    tbl[14] = nv(fpu_round::RNE, 1'b0, 10'd0,   32'h0000_0005, C_UNF);
    tbl[15] = nv(fpu_round::RNE, 1'b0, 10'd300, 32'h0000_0000, C_ZERO);
    tbl[16] = nv(fpu_round::RNE, 1'b1, 10'h200, 32'h0000_0001, C_UNF);
    tbl[17] = nv(fpu_round::RNE, 1'b0, 10'h1FF, 32'h0000_0001, C_INF);

    drive(tbl[5]);
    bus.valid_in    = 1'b0;
    bus.ready_out   = 1'b1;
    bus.flags_clear = 1'b0;

    #12;
    chk("reset valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset ready_in", 32'(bus.ready_in), 32'd1);
    chk("reset payload", r2l(got()), 32'd0);
    chk("reset sticky_ovf", 32'(bus.sticky_overflow), 32'd0);
    chk("reset sticky_unf", 32'(bus.sticky_underflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back table, downstream always ready: each result handshakes on the edge after acceptance.
    s_ovf = 1'b0;
    s_unf = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      e = expect_of(tbl[i]);
      chk($sformatf("vec%0d valid_out", i), 32'(bus.valid_out), 32'd1);
      chk($sformatf("vec%0d payload", i), r2l(got()), r2l(e));
      chk($sformatf("vec%0d sticky_ovf", i), 32'(bus.sticky_overflow), 32'(s_ovf));
      chk($sformatf("vec%0d sticky_unf", i), 32'(bus.sticky_underflow), 32'(s_unf));
      s_ovf = s_ovf | e.ovf;
      s_unf = s_unf | e.unf;
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("drain valid_out", 32'(bus.valid_out), 32'd0);
    chk("drain sticky_ovf", 32'(bus.sticky_overflow), 32'd1);
    chk("drain sticky_unf", 32'(bus.sticky_underflow), 32'd1);

    @(negedge clk);
    bus.flags_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear sticky_ovf", 32'(bus.sticky_overflow), 32'd0);
    chk("clear sticky_unf", 32'(bus.sticky_underflow), 32'd0);

    @(negedge clk);
    bus.flags_clear = 1'b0;
    drive(tbl[2]);
    @(negedge clk);
    drive(tbl[0]);
    @(posedge clk);
    #1;
    chk("pre-clear sticky_unf", 32'(bus.sticky_underflow), 32'd1);
    @(negedge clk);
    bus.valid_in    = 1'b0;
    bus.flags_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear+hs sticky_ovf", 32'(bus.sticky_overflow), 32'd1);
    chk("clear+hs sticky_unf", 32'(bus.sticky_underflow), 32'd0);
    @(negedge clk);
    bus.flags_clear = 1'b0;

    // Stream 8 results with ready_out pattern 1,0,0,1; occupancy model predicts ready_in/valid_out.
    cnt = 0;
    sent = 0;
    recvd = 0;
    for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
      @(negedge clk);
      chk($sformatf("stream c%0d ready_in", cyc), 32'(bus.ready_in), 32'(cnt != 2));
      chk($sformatf("stream c%0d valid_out", cyc), 32'(bus.valid_out), 32'(cnt != 0));
      bus.ready_out = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (sent < 8) drive(tbl[sent]);
      else bus.valid_in = 1'b0;
      acc = bus.valid_in & bus.ready_in;
      hs  = bus.valid_out & bus.ready_out;
      if (hs) begin
        if (q.size() == 0) begin
          chk($sformatf("stream c%0d unexpected output", cyc), 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream out%0d payload", recvd), r2l(got()), r2l(e));
        end
        recvd++;
      end
      if (acc) begin
        q.push_back(expect_of(tbl[sent]));
        sent++;
      end
      cnt = cnt + int'(acc) - int'(hs);
    end
    chk("stream received count", 32'(recvd), 32'd8);
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ready_out = 1'b1;

    // Fill main and skid with downstream stalled, then reset mid-cycle.
    @(negedge clk);
    bus.ready_out = 1'b0;
    drive(tbl[0]);
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    bus.valid_in = 1'b0;
    chk("full ready_in", 32'(bus.ready_in), 32'd0);
    chk("full valid_out", 32'(bus.valid_out), 32'd1);
    chk("full payload", r2l(got()), r2l(expect_of(tbl[0])));
    chk("full sticky_ovf", 32'(bus.sticky_overflow), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset valid_out", 32'(bus.valid_out), 32'd0);
    chk("async reset ready_in", 32'(bus.ready_in), 32'd1);
    chk("async reset sticky_ovf", 32'(bus.sticky_overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.ready_out = 1'b1;
    @(negedge clk);
    chk("post reset valid_out", 32'(bus.valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
